// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg
// Shared constants, FSM state encoding and small helpers for the data-cache
// sequencing controller and its tag store.
//   c_B_VAL_SIZE        byte-enable width of a CPU word
//   c_ADDR_OFFSET_SIZE  byte offset width inside a cache line
//   c_CPU_DATA_SIZE     CPU word width
//   c_RAM_DATA_SIZE     cache line / RAM transfer width
//   c_CACHE_INDEX_SIZE  index width for the default four-line cache
//   c_CNT_SIZE          statistics counter width
package cache_controller_pkg;

   localparam int c_B_VAL_SIZE       = 4;
   localparam int c_ADDR_OFFSET_SIZE = 4;
   localparam int c_CPU_DATA_SIZE    = 32;
   localparam int c_RAM_DATA_SIZE    = 128;
   localparam int c_CACHE_INDEX_SIZE = 2;
   localparam int c_CNT_SIZE         = 16;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WRITEBACK = 3'd2,
      S_FILL      = 3'd3,
      S_UPDATE    = 3'd4,
      S_DONE      = 3'd5
   } cacheState_e;

   // Statistics counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [c_CNT_SIZE-1:0] satInc(input logic [c_CNT_SIZE-1:0] value);
      return (value == '1) ? value : value + 1'b1;
   endfunction

   // Picks one 32-bit word out of a 128-bit line; word 0 is the least significant.
   function automatic logic [c_CPU_DATA_SIZE-1:0] selectWord(
      input logic [c_RAM_DATA_SIZE-1:0] line,
      input logic [1:0]                 sel
   );
      logic [c_CPU_DATA_SIZE-1:0] word;
      word = '0;
      case (sel)
         2'd0: word = line[31:0];
         2'd1: word = line[63:32];
         2'd2: word = line[95:64];
         2'd3: word = line[127:96];
         default: word = '0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/cache_controller_tag_store.sv
// cache_tag_store
// Tag / valid / dirty bookkeeping for the direct-mapped cache.
// Lookup is purely combinational on the requested index; one write port
// updates tag, valid and dirty of a single line per clock.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low clear of all state
//   idx_i, tag_i           lookup index and tag of the current request
//   hit_o                  line at idx_i is valid and holds tag_i
//   victimValid_o          line at idx_i is valid
//   victimDirty_o          line at idx_i is dirty
//   victimTag_o            tag currently stored at idx_i
//   we_i, wIdx_i, wTag_i,
//   wDirty_i               write port: mark line wIdx_i valid with given tag/dirty
module cache_tag_store
   import cache_controller_pkg::*;
#(
   parameter int LINES = 4,
   parameter int IDX_W = 2,
   parameter int TAG_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             hit_o,
   output logic             victimValid_o,
   output logic             victimDirty_o,
   output logic [TAG_W-1:0] victimTag_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wIdx_i,
   input  logic [TAG_W-1:0] wTag_i,
   input  logic             wDirty_i
);

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tags_q [LINES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < LINES; i++) begin
            tags_q[i] <= '0;
         end
      end else if (we_i) begin
         valid_q[wIdx_i] <= 1'b1;
         dirty_q[wIdx_i] <= wDirty_i;
         tags_q[wIdx_i]  <= wTag_i;
      end
   end

   always_comb begin
      victimValid_o = valid_q[idx_i];
      victimDirty_o = dirty_q[idx_i];
      victimTag_o   = tags_q[idx_i];
      hit_o         = valid_q[idx_i] && (tags_q[idx_i] == tag_i);
   end

endmodule

// File: rtl/cache_controller.sv
// cache_controller
// Sequencer for a direct-mapped, write-back, write-allocate data cache.
// Handles one CPU request at a time: tag lookup, optional dirty write-back,
// line fill from RAM, and the update of the line array with the line
// produced by the external merge stage.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   IN_CPU_REQ/WR/ADDR         CPU request (held stable until OUT_CPU_READY)
//   OUT_CPU_READY              one-cycle completion pulse
//   OUT_CPU_DATA               addressed word of the final line, held
//   OUT_RAM_REQ/WE/ADDR/WDATA  RAM line transaction (write-back or read)
//   IN_RAM_ACK, IN_RAM_DATA    RAM one-cycle acknowledge with fill line
//   OUT_SIG_RAM_LOAD           merge stage takes the fill line as base
//   OUT_WR_FLAG                merge stage applies CPU write data
//   OUT_ADDR_OFFSET            latched byte offset for the merge stage
//   OUT_CACHE_LINE             stored line at the request index
//   OUT_FILL_LINE              fill buffer contents
//   IN_MERGED_DATA             merged line written back into the array
//   OUT_HIT_CNT, OUT_MISS_CNT  saturating statistics
module cache_controller
   import cache_controller_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int LINES  = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          IN_CPU_REQ,
   input  logic                          IN_CPU_WR,
   input  logic [ADDR_W-1:0]             IN_CPU_ADDR,
   output logic                          OUT_CPU_READY,
   output logic [c_CPU_DATA_SIZE-1:0]    OUT_CPU_DATA,
   output logic                          OUT_RAM_REQ,
   output logic                          OUT_RAM_WE,
   output logic [ADDR_W-5:0]             OUT_RAM_ADDR,
   output logic [c_RAM_DATA_SIZE-1:0]    OUT_RAM_WDATA,
   input  logic                          IN_RAM_ACK,
   input  logic [c_RAM_DATA_SIZE-1:0]    IN_RAM_DATA,
   output logic                          OUT_SIG_RAM_LOAD,
   output logic                          OUT_WR_FLAG,
   output logic [c_ADDR_OFFSET_SIZE-1:0] OUT_ADDR_OFFSET,
   output logic [c_RAM_DATA_SIZE-1:0]    OUT_CACHE_LINE,
   output logic [c_RAM_DATA_SIZE-1:0]    OUT_FILL_LINE,
   input  logic [c_RAM_DATA_SIZE-1:0]    IN_MERGED_DATA,
   output logic [c_CNT_SIZE-1:0]         OUT_HIT_CNT,
   output logic [c_CNT_SIZE-1:0]         OUT_MISS_CNT
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - c_ADDR_OFFSET_SIZE - IDX_W;

   cacheState_e                   state_q, state_d;
   logic [ADDR_W-1:0]             addr_q;
   logic                          wr_q;
   logic                          fillFlag_q;
   logic [c_RAM_DATA_SIZE-1:0]    fillBuf_q;
   logic [c_RAM_DATA_SIZE-1:0]    lines_q [LINES];
   logic [c_CPU_DATA_SIZE-1:0]    cpuData_q;
   logic [c_CNT_SIZE-1:0]         hitCnt_q;
   logic [c_CNT_SIZE-1:0]         missCnt_q;

   logic [IDX_W-1:0]              reqIdx;
   logic [TAG_W-1:0]              reqTag;
   logic                          tagHit;
   logic                          victimValid;
   logic                          victimDirty;
   logic [TAG_W-1:0]              victimTag;
   logic                          tagWe;
   logic                          tagWDirty;

   assign reqIdx = addr_q[c_ADDR_OFFSET_SIZE +: IDX_W];
   assign reqTag = addr_q[ADDR_W-1 -: TAG_W];

   cache_tag_store #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_tagStore (
      .clk_i         (CLK),
      .rst_ni        (RST_N),
      .idx_i         (reqIdx),
      .tag_i         (reqTag),
      .hit_o         (tagHit),
      .victimValid_o (victimValid),
      .victimDirty_o (victimDirty),
      .victimTag_o   (victimTag),
      .we_i          (tagWe),
      .wIdx_i        (reqIdx),
      .wTag_i        (reqTag),
      .wDirty_i      (tagWDirty)
   );

   // State register plus all datapath registers. The request address and
   // direction are captured once in IDLE and reused for every later phase,
   // so the stored line is only touched in UPDATE; a reset in any earlier
   // phase leaves the array exactly as it was before the reset clears it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         fillFlag_q <= 1'b0;
         fillBuf_q  <= '0;
         cpuData_q  <= '0;
         hitCnt_q   <= '0;
         missCnt_q  <= '0;
         for (int i = 0; i < LINES; i++) begin
            lines_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (IN_CPU_REQ) begin
                  addr_q <= IN_CPU_ADDR;
                  wr_q   <= IN_CPU_WR;
               end
            end
            S_LOOKUP: begin
               if (tagHit) begin
                  hitCnt_q <= satInc(hitCnt_q);
               end else begin
                  missCnt_q <= satInc(missCnt_q);
               end
            end
            S_FILL: begin
               if (IN_RAM_ACK) begin
                  fillBuf_q  <= IN_RAM_DATA;
                  fillFlag_q <= 1'b1;
               end
            end
            S_UPDATE: begin
               lines_q[reqIdx] <= IN_MERGED_DATA;
               cpuData_q       <= selectWord(IN_MERGED_DATA, addr_q[3:2]);
            end
            S_DONE: begin
               fillFlag_q <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and Moore outputs. RAM request signals are decoded from the
   // state alone, so they fall together with an asynchronous reset and stay
   // stable for as long as the FSM waits for the acknowledge. On a hit the
   // new dirty bit keeps any earlier write; on a fill the line is fresh
   // from RAM, so only the current write can make it dirty.
   always_comb begin
      state_d          = state_q;
      OUT_RAM_REQ      = 1'b0;
      OUT_RAM_WE       = 1'b0;
      OUT_RAM_ADDR     = '0;
      OUT_RAM_WDATA    = '0;
      OUT_SIG_RAM_LOAD = 1'b0;
      OUT_WR_FLAG      = 1'b0;
      OUT_CPU_READY    = 1'b0;
      tagWe            = 1'b0;
      tagWDirty        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (IN_CPU_REQ) begin
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (tagHit) begin
               state_d = S_UPDATE;
            end else if (victimValid && victimDirty) begin
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_FILL;
            end
         end
         S_WRITEBACK: begin
            OUT_RAM_REQ   = 1'b1;
            OUT_RAM_WE    = 1'b1;
            OUT_RAM_ADDR  = {victimTag, reqIdx};
            OUT_RAM_WDATA = lines_q[reqIdx];
            if (IN_RAM_ACK) begin
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            OUT_RAM_REQ  = 1'b1;
            OUT_RAM_ADDR = {reqTag, reqIdx};
            if (IN_RAM_ACK) begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            OUT_SIG_RAM_LOAD = fillFlag_q;
            OUT_WR_FLAG      = wr_q;
            tagWe            = 1'b1;
            tagWDirty        = fillFlag_q ? wr_q : (victimDirty | wr_q);
            state_d          = S_DONE;
         end
         S_DONE: begin
            OUT_CPU_READY = 1'b1;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign OUT_CPU_DATA    = cpuData_q;
   assign OUT_ADDR_OFFSET = addr_q[c_ADDR_OFFSET_SIZE-1:0];
   assign OUT_CACHE_LINE  = lines_q[reqIdx];
   assign OUT_FILL_LINE   = fillBuf_q;
   assign OUT_HIT_CNT     = hitCnt_q;
   assign OUT_MISS_CNT    = missCnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller
// Self-checking bench for cache_controller. Provides a RAM responder with a
// programmable acknowledge delay, a behavioural merge stage, and a
// scoreboard of expected CPU read-back words compared on OUT_CPU_READY.
module tb_cache_controller;

   localparam int ADDR_W = 16;
   localparam logic [127:0] RAM_LINE = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

   logic          CLK;
   logic          RST_N;
   logic          IN_CPU_REQ;
   logic          IN_CPU_WR;
   logic [15:0]   IN_CPU_ADDR;
   logic          OUT_CPU_READY;
   logic [31:0]   OUT_CPU_DATA;
   logic          OUT_RAM_REQ;
   logic          OUT_RAM_WE;
   logic [11:0]   OUT_RAM_ADDR;
   logic [127:0]  OUT_RAM_WDATA;
   logic          IN_RAM_ACK;
   logic [127:0]  IN_RAM_DATA;
   logic          OUT_SIG_RAM_LOAD;
   logic          OUT_WR_FLAG;
   logic [3:0]    OUT_ADDR_OFFSET;
   logic [127:0]  OUT_CACHE_LINE;
   logic [127:0]  OUT_FILL_LINE;
   logic [127:0]  IN_MERGED_DATA;
   logic [15:0]   OUT_HIT_CNT;
   logic [15:0]   OUT_MISS_CNT;

   logic [31:0]   cpuWdata;
   logic [3:0]    cpuBe;

   int            compared   = 0;
   int            mismatched = 0;
   logic [31:0]   expQ [$];
   logic          txnWe [$];
   logic [11:0]   txnAddr [$];
   logic [127:0]  txnWdata [$];
   int            ramDelay = 0;
   int            lastTxnCycles = 0;
   logic          sawWrFlag, sawRamLoad, sawRamReq;

   cache_controller #(
      .ADDR_W (ADDR_W),
      .LINES  (4)
   ) dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .IN_CPU_REQ       (IN_CPU_REQ),
      .IN_CPU_WR        (IN_CPU_WR),
      .IN_CPU_ADDR      (IN_CPU_ADDR),
      .OUT_CPU_READY    (OUT_CPU_READY),
      .OUT_CPU_DATA     (OUT_CPU_DATA),
      .OUT_RAM_REQ      (OUT_RAM_REQ),
      .OUT_RAM_WE       (OUT_RAM_WE),
      .OUT_RAM_ADDR     (OUT_RAM_ADDR),
      .OUT_RAM_WDATA    (OUT_RAM_WDATA),
      .IN_RAM_ACK       (IN_RAM_ACK),
      .IN_RAM_DATA      (IN_RAM_DATA),
      .OUT_SIG_RAM_LOAD (OUT_SIG_RAM_LOAD),
      .OUT_WR_FLAG      (OUT_WR_FLAG),
      .OUT_ADDR_OFFSET  (OUT_ADDR_OFFSET),
      .OUT_CACHE_LINE   (OUT_CACHE_LINE),
      .OUT_FILL_LINE    (OUT_FILL_LINE),
      .IN_MERGED_DATA   (IN_MERGED_DATA),
      .OUT_HIT_CNT      (OUT_HIT_CNT),
      .OUT_MISS_CNT     (OUT_MISS_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural merge stage: start from the fill line or the stored line,
   // then overlay the enabled CPU bytes into the addressed word on a write.
   function automatic logic [127:0] mergeLine(
      input logic         ramLoad,
      input logic         wrFlag,
      input logic [3:0]   offset,
      input logic [127:0] cacheLine,
      input logic [127:0] fillLine,
      input logic [31:0]  wdata,
      input logic [3:0]   be
   );
      logic [127:0] line;
      line = ramLoad ? fillLine : cacheLine;
      if (wrFlag) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) line[offset[3:2]*32 + b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      return line;
   endfunction

   assign IN_MERGED_DATA = mergeLine(OUT_SIG_RAM_LOAD, OUT_WR_FLAG, OUT_ADDR_OFFSET,
                                     OUT_CACHE_LINE, OUT_FILL_LINE, cpuWdata, cpuBe);

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // RAM responder: logs each transaction on its first request cycle, checks
   // that the request stays stable while waiting, acknowledges after
   // ramDelay extra cycles, and checks that a fill request drops afterwards.
   logic        inTxn = 1'b0;
   int          waitCnt = 0;
   logic        lastWe;
   logic [11:0] lastAddr;
   logic        ackWasFill = 1'b0;

   initial begin
      IN_RAM_ACK  = 1'b0;
      IN_RAM_DATA = '0;
      forever begin
         @(negedge CLK);
         if (IN_RAM_ACK) begin
            IN_RAM_ACK = 1'b0;
            if (ackWasFill) checkOutput("reqDropAfterFillAck", OUT_RAM_REQ, 1'b0);
         end
         if (!OUT_RAM_REQ) begin
            inTxn = 1'b0;
         end else begin
            if (!inTxn) begin
               inTxn    = 1'b1;
               waitCnt  = 0;
               lastWe   = OUT_RAM_WE;
               lastAddr = OUT_RAM_ADDR;
               txnWe.push_back(OUT_RAM_WE);
               txnAddr.push_back(OUT_RAM_ADDR);
               txnWdata.push_back(OUT_RAM_WDATA);
            end else begin
               checkOutput("ramReqStable", {OUT_RAM_WE, OUT_RAM_ADDR}, {lastWe, lastAddr});
            end
            if (waitCnt == ramDelay) begin
               IN_RAM_ACK    = 1'b1;
               IN_RAM_DATA   = RAM_LINE;
               inTxn         = 1'b0;
               ackWasFill    = !lastWe;
               lastTxnCycles = waitCnt + 1;
            end else begin
               waitCnt++;
            end
         end
      end
   end

   // Scoreboard consumer: every completion pops one expected word.
   logic [31:0] expWord;
   initial begin
      forever begin
         @(negedge CLK);
         if (OUT_CPU_READY) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedReady", 1'b1, 1'b0);
            end else begin
               expWord = expQ.pop_front();
               checkOutput("cpuData", OUT_CPU_DATA, expWord);
            end
         end
      end
   end

   task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] expData,
                                output int latency);
      @(negedge CLK);
      IN_CPU_REQ  = 1'b1;
      IN_CPU_WR   = wr;
      IN_CPU_ADDR = addr;
      cpuBe       = be;
      cpuWdata    = wdata;
      expQ.push_back(expData);
      sawWrFlag   = 1'b0;
      sawRamLoad  = 1'b0;
      sawRamReq   = 1'b0;
      latency     = 0;
      while (latency < 200) begin
         @(negedge CLK);
         latency++;
         sawWrFlag  = sawWrFlag | OUT_WR_FLAG;
         sawRamLoad = sawRamLoad | OUT_SIG_RAM_LOAD;
         sawRamReq  = sawRamReq | OUT_RAM_REQ;
         if (OUT_CPU_READY) break;
      end
      if (!OUT_CPU_READY) checkOutput("readyTimeout", 1'b0, 1'b1);
      IN_CPU_REQ = 1'b0;
   endtask

   task automatic clearTxnLog();
      txnWe.delete();
      txnAddr.delete();
      txnWdata.delete();
   endtask

   initial begin
      int lat;
      int waitCycles;
      RST_N       = 1'b0;
      IN_CPU_REQ  = 1'b0;
      IN_CPU_WR   = 1'b0;
      IN_CPU_ADDR = '0;
      cpuWdata    = '0;
      cpuBe       = '0;
      repeat (3) @(negedge CLK);

      checkOutput("rstRamReq",   OUT_RAM_REQ, 1'b0);
      checkOutput("rstReady",    OUT_CPU_READY, 1'b0);
      checkOutput("rstCounters", {OUT_HIT_CNT, OUT_MISS_CNT}, 32'h0);
      checkOutput("rstCpuData",  OUT_CPU_DATA, 32'h0);
      checkOutput("rstRamAddr",  OUT_RAM_ADDR, 12'h0);
      checkOutput("rstRamWdata", OUT_RAM_WDATA, 128'h0);
      checkOutput("rstMergeCtl", {OUT_SIG_RAM_LOAD, OUT_WR_FLAG, OUT_ADDR_OFFSET}, 6'h0);
      checkOutput("rstLines",    OUT_CACHE_LINE | OUT_FILL_LINE, 128'h0);
      RST_N = 1'b1;

      $display("[TB] cold read miss");
      clearTxnLog();
      applyStimulus(1'b0, 16'h0048, 4'h0, 32'h0, 32'hCCCCCCCC, lat);
      checkOutput("coldTxnCount", txnAddr.size(), 1);
      if (txnAddr.size() >= 1) begin
         checkOutput("coldFillAddr", txnAddr[0], 12'h004);
         checkOutput("coldFillWe",   txnWe[0], 1'b0);
      end
      checkOutput("coldMissCnt", OUT_MISS_CNT, 16'd1);
      checkOutput("coldHitCnt",  OUT_HIT_CNT, 16'd0);
      checkOutput("coldLatency", lat, 4);
      checkOutput("coldRamLoad", sawRamLoad, 1'b1);

      $display("[TB] read hit");
      clearTxnLog();
      applyStimulus(1'b0, 16'h0044, 4'h0, 32'h0, 32'hBBBBBBBB, lat);
      checkOutput("hitLatency", lat, 3);
      checkOutput("hitNoRamReq", sawRamReq, 1'b0);
      checkOutput("hitHitCnt", OUT_HIT_CNT, 16'd1);
      checkOutput("hitWrFlag", sawWrFlag, 1'b0);

      $display("[TB] byte-enable write hit");
      applyStimulus(1'b1, 16'h0044, 4'b0011, 32'h12345678, 32'hBBBB5678, lat);
      checkOutput("wrWrFlag",  sawWrFlag, 1'b1);
      checkOutput("wrRamLoad", sawRamLoad, 1'b0);
      checkOutput("wrHitCnt",  OUT_HIT_CNT, 16'd2);

      $display("[TB] dirty eviction");
      clearTxnLog();
      applyStimulus(1'b0, 16'h0084, 4'h0, 32'h0, 32'hBBBBBBBB, lat);
      checkOutput("evTxnCount", txnAddr.size(), 2);
      if (txnAddr.size() >= 2) begin
         checkOutput("evWbWe",    txnWe[0], 1'b1);
         checkOutput("evWbAddr",  txnAddr[0], 12'h004);
         checkOutput("evWbWord1", txnWdata[0][63:32], 32'hBBBB5678);
         checkOutput("evFillWe",  txnWe[1], 1'b0);
         checkOutput("evFillAddr", txnAddr[1], 12'h008);
      end
      checkOutput("evLatency", lat, 5);
      checkOutput("evMissCnt", OUT_MISS_CNT, 16'd2);

      $display("[TB] slow RAM clean miss");
      ramDelay = 5;
      clearTxnLog();
      applyStimulus(1'b0, 16'h0048, 4'h0, 32'h0, 32'hCCCCCCCC, lat);
      checkOutput("slowTxnCount", txnAddr.size(), 1);
      if (txnAddr.size() >= 1) checkOutput("slowCleanNoWb", txnWe[0], 1'b0);
      checkOutput("slowReqCycles", lastTxnCycles, 6);
      checkOutput("slowLatency", lat, 9);
      checkOutput("slowMissCnt", OUT_MISS_CNT, 16'd3);

      $display("[TB] reset during fill");
      ramDelay = 10;
      @(negedge CLK);
      IN_CPU_REQ  = 1'b1;
      IN_CPU_WR   = 1'b0;
      IN_CPU_ADDR = 16'h00C8;
      waitCycles  = 0;
      while (!OUT_RAM_REQ && waitCycles < 20) begin
         @(negedge CLK);
         waitCycles++;
      end
      checkOutput("midFillStarted", OUT_RAM_REQ, 1'b1);
      repeat (2) @(negedge CLK);
      RST_N      = 1'b0;
      IN_CPU_REQ = 1'b0;
      #1;
      checkOutput("midRstRamReq",   OUT_RAM_REQ, 1'b0);
      checkOutput("midRstCounters", {OUT_HIT_CNT, OUT_MISS_CNT}, 32'h0);
      checkOutput("midRstCpuData",  OUT_CPU_DATA, 32'h0);
      checkOutput("midRstLine",     OUT_CACHE_LINE, 128'h0);
      repeat (2) @(negedge CLK);
      RST_N    = 1'b1;
      ramDelay = 0;
      clearTxnLog();
      applyStimulus(1'b0, 16'h0048, 4'h0, 32'h0, 32'hCCCCCCCC, lat);
      checkOutput("reReadTxnCount", txnAddr.size(), 1);
      if (txnAddr.size() >= 1) checkOutput("reReadFillAddr", txnAddr[0], 12'h004);
      checkOutput("reReadMissCnt", OUT_MISS_CNT, 16'd1);
      checkOutput("reReadHitCnt",  OUT_HIT_CNT, 16'd0);

      repeat (2) @(negedge CLK);
      checkOutput("scoreboardDrained", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the direct-mapped, write-back, write-allocate data cache. It accepts one CPU request at a time and holds the tag/valid/dirty state and the line data array. It runs RAM write-back and line-fill transactions and drives the line-merge stage's select and write controls (`SIG_RAM_LOAD`, `WR_FLAG`, `ADDR_OFFSET`). The merged 128-bit line returned by that stage is what this block writes into the data array.

## Interface
Parameters:
- `ADDR_W`, 16: CPU byte-address width. Layout: tag = `[ADDR_W-1:6]`, index = `[5:4]`, offset = `[3:0]`, word select = `[3:2]`.
- `LINES`, 4: number of cache lines. Index width is log2(`LINES`).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IN_CPU_REQ` in 1: request valid; sampled only in IDLE.
- `IN_CPU_WR` in 1: 1 = write, 0 = read.
- `IN_CPU_ADDR` in `ADDR_W`: byte address.
- `OUT_CPU_READY` out 1: one-cycle completion pulse.
- `OUT_CPU_DATA` out 32: addressed word after the operation; holds until the next completion.
- `OUT_RAM_REQ` out 1: RAM transaction request.
- `OUT_RAM_WE` out 1: 1 = line write-back, 0 = line read.
- `OUT_RAM_ADDR` out `ADDR_W-4`: line address.
- `OUT_RAM_WDATA` out 128: write-back line.
- `IN_RAM_ACK` in 1: one-cycle acknowledge.
- `IN_RAM_DATA` in 128: fill line, valid with ack.
- `OUT_SIG_RAM_LOAD` out 1: merge stage selects the fill line.
- `OUT_WR_FLAG` out 1: merge stage applies CPU data/byte enables.
- `OUT_ADDR_OFFSET` out 4: latched offset to merge stage.
- `OUT_CACHE_LINE` out 128: current stored line to merge stage.
- `OUT_FILL_LINE` out 128: fill buffer to merge stage.
- `IN_MERGED_DATA` in 128: merge-stage result.
- `OUT_HIT_CNT`, `OUT_MISS_CNT` out 16: saturating statistics counters.

CPU write data and byte enables go straight to the merge stage. The CPU holds them, and `IN_CPU_ADDR`/`IN_CPU_WR`, stable from request until `OUT_CPU_READY`.

## Operation
States: IDLE, LOOKUP, WRITEBACK, FILL, UPDATE, DONE.
- **IDLE:** on `IN_CPU_REQ`=1, latch addr/wr and go to LOOKUP.
- **LOOKUP:**
  - Hit (valid and tag match): `OUT_HIT_CNT`+1, go to UPDATE.
  - Miss: `OUT_MISS_CNT`+1. If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
- **WRITEBACK:** `REQ`=1, `WE`=1, `ADDR`={stored tag, index}, `WDATA`=stored line. On ack, go to FILL.
- **FILL:** `REQ`=1, `WE`=0, `ADDR`={request tag, index}. On ack, capture `IN_RAM_DATA` into the fill buffer, set `fill_flag`, go to UPDATE.
- **UPDATE:**
  - `OUT_SIG_RAM_LOAD`=`fill_flag`, `OUT_WR_FLAG`=latched wr.
  - At the edge: line[index] ← `IN_MERGED_DATA`; tag ← request tag; valid ← 1.
  - Dirty ← wr on a fill; dirty ← dirty | wr on a hit.
  - `OUT_CPU_DATA` ← word `[3:2]` of `IN_MERGED_DATA`. On a write this returns the written word.
  - Go to DONE.
- **DONE:** `OUT_CPU_READY`=1, clear `fill_flag`, go to IDLE.

Rules:
- `OUT_SIG_RAM_LOAD` and `OUT_WR_FLAG` are 0 outside UPDATE.
- Counters saturate at 0xFFFF.

## Timing
- **Reset (async, immediate):**
  - State IDLE.
  - All outputs 0: `OUT_RAM_REQ`, ready, counters, `OUT_CPU_DATA`, RAM address/wdata, merge controls.
  - Valid/dirty/tag cleared; data array and fill buffer zeroed.
- **Reset mid-transaction:** `OUT_RAM_REQ` drops with `RST_N`, no line is modified, and any pending ack is ignored.
- **Hit latency:** request sampled at edge 0 → LOOKUP, UPDATE → `OUT_CPU_READY` high in cycle 3.
- **Clean-miss latency:** 3 cycles + FILL wait. A dirty miss adds the WRITEBACK wait.
- **RAM handshake:**
  - `REQ`/`WE`/`ADDR`/`WDATA` stay stable until the ack is sampled; `REQ` falls the cycle after ack.
  - Ack seen while `REQ`=0 is ignored. Ack in the first request cycle is legal (1-cycle transaction).
- **Back-to-back requests:** `IN_CPU_REQ` held high through DONE starts the next request the cycle after READY.

## Structure
- Add to `Constants.vh`: `c_B_VAL_SIZE`=4, `c_ADDR_OFFSET_SIZE`=4, `c_CPU_DATA_SIZE`=32, `c_RAM_DATA_SIZE`=128, plus new `c_CACHE_INDEX_SIZE` and the state encodings.
- One sub-module: `cache_tag_store`. It holds the tag/valid/dirty arrays, with a combinational hit/dirty lookup and a single write port, asynchronously cleared.

## Test plan
Setup: `LINES`=4; RAM model returns line 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
1. **Cold read miss:** after reset, read 0x0048 → FILL with `OUT_RAM_ADDR`=0x004, `WE`=0 → READY, `OUT_CPU_DATA`=0xCCCCCCCC, `MISS_CNT`=1.
2. **Read hit:** read 0x0044 → READY exactly 3 cycles after request, `OUT_CPU_DATA`=0xBBBBBBBB, `OUT_RAM_REQ` never high, `HIT_CNT`=1.
3. **Byte-enable write hit:** write 0x0044, byte enables 0011, data 0x12345678 → `OUT_WR_FLAG`=1 in UPDATE, `OUT_CPU_DATA`=0xBBBB5678, line 0 dirty.
4. **Dirty eviction:** read 0x0084 → WRITEBACK at 0x004 with `WDATA[63:32]`=0xBBBB5678, then FILL at 0x008 → `OUT_CPU_DATA`=0xBBBBBBBB, line clean.
5. **Slow RAM:** delay ack 5 cycles → `REQ`/`ADDR`/`WE` stable for all 6 cycles, `REQ`=0 the cycle after ack.
6. **Reset during FILL:** assert `RST_N`=0 mid-FILL → `OUT_RAM_REQ`=0 immediately, counters 0; a re-read of 0x0048 misses again.
